// File: rtl/rule_conf_multistage.sv
// Parser rule configurator: per-stage shadow registers with an atomic, idle-gated commit to the active outputs.
// Optional readback path enabled by defining RULE_CONF_READBACK_EN.
module rule_conf_multistage #(
  parameter int STAGE_NUM         = 3,
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_OFFSET_WIDTH = 8,
  parameter int TYPE_WIDTH        = 16,
  parameter int RULE_NUM          = 16,
  parameter int KEY_FILED_NUM     = 8,
  parameter int KEY_OFFSET_WIDTH  = 8
) (
  input  logic                                                     i_clk,
  input  logic                                                     i_rst_n,
  input  logic                                                     i_rule_wren,
  input  logic                                                     i_rule_rden,
  input  logic [31:0]                                              i_rule_addr,
  input  logic [31:0]                                              i_rule_wdata,
  output logic [31:0]                                              o_rule_rdata,
  output logic                                                     o_rule_rvalid,
  input  logic [STAGE_NUM-1:0]                                     i_stage_idle,
  output logic                                                     o_busy,
  output logic [15:0]                                              o_err_cnt,
  output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] o_type_offset,
  output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]        o_typeRule_typeData,
  output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]        o_typeRule_typeMask,
  output logic [STAGE_NUM-1:0][KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0] o_typeRule_keyOffset,
  output logic [STAGE_NUM-1:0][RULE_NUM-1:0]                       o_typeRule_wren,
  output logic [STAGE_NUM-1:0]                                     o_typeRule_valid
);
  localparam int SW  = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
  localparam int TIW = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
  localparam int KIW = (KEY_FILED_NUM > 1) ? $clog2(KEY_FILED_NUM) : 1;
  localparam int RW  = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_APPLY = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [1:0]    region;
  logic [3:0]    stage_id;
  logic [5:0]    idx;
  logic          stage_ok, idx_ok, rule_ok, busy_hit;
  logic          wr_ok, commit_ok, wr_err, rd_err, applying;
  logic [SW-1:0] pend_stage_reg;
  logic [RW-1:0] pend_rule_reg;
  logic          pend_valid_reg;
  logic          unused_ok;

  assign region   = i_rule_addr[17:16];
  assign stage_id = i_rule_addr[11:8];
  assign idx      = i_rule_addr[5:0];
  assign unused_ok = &{1'b0, i_rule_addr[31:18], i_rule_addr[15:12], i_rule_addr[7:6],
                       i_rule_wdata, i_rule_rden};

  always_comb begin
    idx_ok = 1'b0;
    case (region)
      2'd0, 2'd1: idx_ok = int'(idx) < TYPE_NUM;
      2'd2:       idx_ok = int'(idx) < KEY_FILED_NUM;
      default:    idx_ok = (idx == 6'd0);
    endcase
  end

  assign stage_ok  = int'(stage_id) < STAGE_NUM;
  assign rule_ok   = int'(i_rule_wdata[5:0]) < RULE_NUM;
  // While a commit is in flight, its stage is frozen and no second commit may start.
  assign busy_hit  = o_busy && ((region == 2'd3) || (int'(stage_id) == int'(pend_stage_reg)));
  assign wr_ok     = i_rule_wren && stage_ok && idx_ok && !busy_hit && ((region != 2'd3) || rule_ok);
  assign commit_ok = wr_ok && (region == 2'd3);
  assign wr_err    = i_rule_wren && !wr_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (commit_ok) state_next = S_WAIT;
      S_WAIT:  if (i_stage_idle[pend_stage_reg]) state_next = S_APPLY;
      S_APPLY: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state_reg != S_IDLE);
    applying = (state_reg == S_APPLY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_stage_reg  <= '0;
      pend_rule_reg   <= '0;
      pend_valid_reg  <= 1'b0;
      o_typeRule_wren <= '0;
      o_err_cnt       <= '0;
    end else begin
      if (commit_ok) begin
        pend_stage_reg <= stage_id[SW-1:0];
        pend_rule_reg  <= i_rule_wdata[RW-1:0];
        pend_valid_reg <= i_rule_wdata[8];
      end
      o_typeRule_wren <= '0;
      if (applying) o_typeRule_wren[pend_stage_reg][pend_rule_reg] <= 1'b1;
      if ((wr_err || rd_err) && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

`ifdef RULE_CONF_READBACK_EN
  logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     sh_off_all;
  logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]            sh_data_all, sh_mask_all;
  logic [STAGE_NUM-1:0][KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0] sh_key_all;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
      logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     sh_off_reg, act_off_reg;
      logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            sh_data_reg, act_data_reg;
      logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            sh_mask_reg, act_mask_reg;
      logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0] sh_key_reg, act_key_reg;
      logic                                           valid_reg;
      logic                                           sel;

      assign sel = wr_ok && (int'(stage_id) == gi);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sh_off_reg   <= '0;
          sh_data_reg  <= '0;
          sh_mask_reg  <= '0;
          sh_key_reg   <= '0;
          act_off_reg  <= '0;
          act_data_reg <= '0;
          act_mask_reg <= '0;
          act_key_reg  <= '0;
          valid_reg    <= 1'b0;
        end else begin
          if (sel) begin
            case (region)
              2'd0: sh_off_reg[idx[TIW-1:0]] <= i_rule_wdata[TYPE_OFFSET_WIDTH-1:0];
              2'd1: begin
                sh_data_reg[idx[TIW-1:0]] <= i_rule_wdata[16 +: TYPE_WIDTH];
                sh_mask_reg[idx[TIW-1:0]] <= i_rule_wdata[TYPE_WIDTH-1:0];
              end
              2'd2: sh_key_reg[idx[KIW-1:0]] <= i_rule_wdata[KEY_OFFSET_WIDTH-1:0];
              default: ;
            endcase
          end
          if (applying && (int'(pend_stage_reg) == gi)) begin
            act_off_reg  <= sh_off_reg;
            act_data_reg <= sh_data_reg;
            act_mask_reg <= sh_mask_reg;
            act_key_reg  <= sh_key_reg;
            valid_reg    <= pend_valid_reg;
          end
        end
      end

      assign o_type_offset[gi]        = act_off_reg;
      assign o_typeRule_typeData[gi]  = act_data_reg;
      assign o_typeRule_typeMask[gi]  = act_mask_reg;
      assign o_typeRule_keyOffset[gi] = act_key_reg;
      assign o_typeRule_valid[gi]     = valid_reg;
`ifdef RULE_CONF_READBACK_EN
      assign sh_off_all[gi]  = sh_off_reg;
      assign sh_data_all[gi] = sh_data_reg;
      assign sh_mask_all[gi] = sh_mask_reg;
      assign sh_key_all[gi]  = sh_key_reg;
`endif
    end
  endgenerate

`ifdef RULE_CONF_READBACK_EN
  logic [31:0] rd_val;
  logic        rd_ok;

  always_comb begin
    rd_ok  = (region == 2'd3) ? (idx == 6'd0) : (stage_ok && idx_ok);
    rd_val = '0;
    if (rd_ok) begin
      case (region)
        2'd0: rd_val = 32'(sh_off_all[stage_id[SW-1:0]][idx[TIW-1:0]]);
        2'd1: rd_val = {16'(sh_data_all[stage_id[SW-1:0]][idx[TIW-1:0]]),
                        16'(sh_mask_all[stage_id[SW-1:0]][idx[TIW-1:0]])};
        2'd2: rd_val = 32'(sh_key_all[stage_id[SW-1:0]][idx[KIW-1:0]]);
        default: rd_val = {30'b0, o_busy, applying};
      endcase
    end
  end

  assign rd_err = i_rule_rden && !rd_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rule_rdata  <= '0;
      o_rule_rvalid <= 1'b0;
    end else begin
      o_rule_rvalid <= i_rule_rden;
      if (i_rule_rden) o_rule_rdata <= rd_val;
    end
  end
`else
  assign rd_err        = 1'b0;
  assign o_rule_rdata  = '0;
  assign o_rule_rvalid = 1'b0;
`endif
endmodule

// File: tb/tb_rule_conf_multistage.sv
// Bench for rule_conf_multistage: directed table, hand-written commit sequences,
// then random traffic checked against a transaction-level model of shadow/active state.
module tb_rule_conf_multistage;
  localparam int SN = 3, TN = 4, OW = 8, TW = 16, RN = 16, KN = 8, KW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wren, rden;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [SN-1:0] idle;
  logic        busy;
  logic [15:0] err;
  logic [SN-1:0][TN-1:0][OW-1:0] toff;
  logic [SN-1:0][TN-1:0][TW-1:0] tdata, tmask;
  logic [SN-1:0][KN-1:0][KW-1:0] tkey;
  logic [SN-1:0][RN-1:0]         twren;
  logic [SN-1:0]                 tvalid;

  always #5 clk = ~clk;

  rule_conf_multistage #(
    .STAGE_NUM(SN), .TYPE_NUM(TN), .TYPE_OFFSET_WIDTH(OW), .TYPE_WIDTH(TW),
    .RULE_NUM(RN), .KEY_FILED_NUM(KN), .KEY_OFFSET_WIDTH(KW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rule_wren(wren), .i_rule_rden(rden),
    .i_rule_addr(addr), .i_rule_wdata(wdata), .o_rule_rdata(rdata), .o_rule_rvalid(rvalid),
    .i_stage_idle(idle), .o_busy(busy), .o_err_cnt(err),
    .o_type_offset(toff), .o_typeRule_typeData(tdata), .o_typeRule_typeMask(tmask),
    .o_typeRule_keyOffset(tkey), .o_typeRule_wren(twren), .o_typeRule_valid(tvalid)
  );

  int vecs = 0, miss = 0;

  // Reference model: shadow/active images plus the lifecycle of one outstanding commit
  // (0 none, 1 waiting for idle, 2 idle seen, lands on next edge).
  logic [SN-1:0][TN-1:0][OW-1:0] m_sh_off, m_off;
  logic [SN-1:0][TN-1:0][TW-1:0] m_sh_data, m_data, m_sh_mask, m_mask;
  logic [SN-1:0][KN-1:0][KW-1:0] m_sh_key, m_key;
  logic [SN-1:0][RN-1:0]         m_wren;
  logic [SN-1:0]                 m_valid;
  logic [15:0]                   m_err;
  logic [31:0]                   m_rdata;
  logic                          m_rvalid;
  int m_life, m_ps, m_pr;
  logic m_pv;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] exp_err;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] mk(input int r, input int s, input int i);
    return 32'((r << 16) | (s << 8) | i);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sh_off = '0; m_off = '0; m_sh_data = '0; m_data = '0;
    m_sh_mask = '0; m_mask = '0; m_sh_key = '0; m_key = '0;
    m_wren = '0; m_valid = '0; m_err = '0; m_rdata = '0; m_rvalid = 1'b0;
    m_life = 0; m_ps = 0; m_pr = 0; m_pv = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int r, s, i, lim, rule;
    bit old_busy, s_ok, i_ok, w_ok, r_ok, e;
    r = int'(addr[17:16]); s = int'(addr[11:8]); i = int'(addr[5:0]);
    rule = int'(wdata[5:0]);
    old_busy = (m_life != 0);
    s_ok = (s < SN);
    lim = (r < 2) ? TN : ((r == 2) ? KN : 1);
    i_ok = (i < lim);
    r_ok = (r == 3) ? (i == 0) : (s_ok && i_ok);
    w_ok = wren && s_ok && i_ok && !(old_busy && (r == 3 || s == m_ps)) && (r != 3 || rule < RN);
    e = wren && !w_ok;
`ifdef RULE_CONF_READBACK_EN
    e = e || (rden && !r_ok);
    m_rvalid = rden;
    if (rden) begin
      m_rdata = '0;
      if (r_ok) begin
        case (r)
          0: m_rdata = 32'(m_sh_off[s][i]);
          1: m_rdata = {m_sh_data[s][i], m_sh_mask[s][i]};
          2: m_rdata = 32'(m_sh_key[s][i]);
          default: m_rdata = {30'b0, old_busy, m_life == 2};
        endcase
      end
    end
`endif
    m_wren = '0;
    if (m_life == 2) begin
      m_off[m_ps] = m_sh_off[m_ps]; m_data[m_ps] = m_sh_data[m_ps];
      m_mask[m_ps] = m_sh_mask[m_ps]; m_key[m_ps] = m_sh_key[m_ps];
      m_valid[m_ps] = m_pv; m_wren[m_ps][m_pr] = 1'b1; m_life = 0;
    end else if (m_life == 1 && idle[m_ps]) begin
      m_life = 2;
    end
    if (w_ok) begin
      case (r)
        0: m_sh_off[s][i] = wdata[7:0];
        1: begin m_sh_data[s][i] = wdata[31:16]; m_sh_mask[s][i] = wdata[15:0]; end
        2: m_sh_key[s][i] = wdata[7:0];
        default: begin m_life = 1; m_ps = s; m_pr = rule; m_pv = wdata[8]; end
      endcase
    end
    if (e && m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  task automatic check_all();
    chk("busy", busy, m_life != 0);
    chk("err_cnt", err, m_err);
    chk("type_offset", toff, m_off);
    chk("type_data", tdata, m_data);
    chk("type_mask", tmask, m_mask);
    chk("key_offset", tkey, m_key);
    chk("rule_valid", tvalid, m_valid);
    chk("rule_wren", twren, m_wren);
    chk("rvalid", rvalid, m_rvalid);
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_bus();
    wren = 1'b0; rden = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [SN-1:0][RN-1:0] one_hot;
    tbl[0] = '{1'b1, mk(0, 1, 2),  32'h0000_001C, 16'd0};
    tbl[1] = '{1'b1, mk(0, 15, 0), 32'h0000_00AA, 16'd1};
    tbl[2] = '{1'b1, mk(2, 0, 40), 32'h0000_00BB, 16'd2};
    tbl[3] = '{1'b1, mk(0, 0, 4),  32'h0000_00CC, 16'd3};
    tbl[4] = '{1'b1, mk(3, 0, 1),  32'h0000_0101, 16'd4};
    tbl[5] = '{1'b1, mk(1, 2, 3),  32'hBEEF_1234, 16'd4};
    tbl[6] = '{1'b1, mk(2, 2, 7),  32'h0000_0033, 16'd4};
    tbl[7] = '{1'b1, mk(3, 0, 0),  32'h0000_0114, 16'd5};

    idle = '1;
    do_reset();
    chk("reset err_cnt", err, 16'd0);

    // Directed table: shadow writes and out-of-range drops; nothing reaches active outputs.
    for (int k = 0; k < 8; k++) begin
      wren = tbl[k].wr; addr = tbl[k].a; wdata = tbl[k].d;
      step();
      chk($sformatf("tbl%0d err_cnt", k), err, tbl[k].exp_err);
      chk($sformatf("tbl%0d busy", k), busy, 1'b0);
    end
    idle_bus();
    chk("shadow only", toff, '0);

    // Commit stage1 rule 5 valid with idle high: lands exactly at T+3.
    wren = 1'b1; addr = mk(3, 1, 0); wdata = 32'h0000_0105;
    step();
    chk("T+1 busy", busy, 1'b1);
    idle_bus();
    step();
    chk("T+2 busy", busy, 1'b1);
    chk("T+2 offset", toff[1][2], 8'h00);
    step();
    one_hot = '0; one_hot[1][5] = 1'b1;
    chk("T+3 offset", toff[1][2], 8'h1C);
    chk("T+3 wren", twren, one_hot);
    chk("T+3 valid", tvalid, 3'b010);
    chk("T+3 busy", busy, 1'b0);
    chk("T+3 other stages", {toff[0], toff[2]}, '0);
    step();
    chk("T+4 wren", twren, '0);

    // Stall on busy stage0 for 10 cycles; commit and same-stage write are dropped.
    do_reset();
    wren = 1'b1; addr = mk(0, 0, 0); wdata = 32'h55;
    step();
    idle = 3'b110;
    addr = mk(3, 0, 0); wdata = 32'h0000_0103;
    step();
    for (int c = 0; c < 10; c++) begin
      wren = (c < 3);
      if (c == 0) begin addr = mk(3, 2, 0); wdata = 32'h0000_0101; end
      if (c == 1) begin addr = mk(0, 0, 1); wdata = 32'h66; end
      if (c == 2) begin addr = mk(0, 2, 0); wdata = 32'h77; end
      step();
      chk($sformatf("stall%0d busy", c), busy, 1'b1);
      chk($sformatf("stall%0d offset", c), toff[0][0], 8'h00);
    end
    idle_bus();
    chk("stall err_cnt", err, 16'd2);
    idle = '1;
    step();
    step();
    one_hot = '0; one_hot[0][3] = 1'b1;
    chk("stall apply offset", toff[0], 32'h0000_0055);
    chk("stall apply wren", twren, one_hot);
    chk("stall apply valid", tvalid, 3'b001);

    // Reset in WAIT_IDLE: everything clears, no later wren pulse.
    do_reset();
    idle = 3'b000;
    wren = 1'b1; addr = mk(3, 2, 0); wdata = 32'h0000_0107;
    step();
    idle_bus();
    step();
    chk("pre-reset busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("mid reset wren", twren, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle = '1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post reset wren%0d", c), twren, '0);
    end

`ifdef RULE_CONF_READBACK_EN
    wren = 1'b1; addr = mk(2, 2, 3); wdata = 32'h2A;
    step();
    wren = 1'b0; rden = 1'b1;
    step();
    chk("readback rvalid", rvalid, 1'b1);
    chk("readback rdata", rdata, 32'h2A);
    rden = 1'b0;
    step();
    chk("readback rvalid drop", rvalid, 1'b0);
`else
    rden = 1'b1; addr = mk(0, 1, 2);
    step();
    chk("no readback rvalid", rvalid, 1'b0);
    rden = 1'b0;
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      int r, s, i;
      r = int'($urandom_range(0, 3));
      s = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) i = 40;
      else if (r == 3) i = ($urandom_range(0, 5) == 0) ? 1 : 0;
      else i = int'($urandom_range(0, 8));
      wren = 1'($urandom_range(0, 1));
      rden = ($urandom_range(0, 3) == 0);
      addr = mk(r, s, i);
      wdata = $urandom;
      if (r == 3) wdata[5:0] = 6'($urandom_range(0, 17));
      idle = 3'($urandom_range(0, 7));
      step();
    end
    idle_bus();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
